// File: rtl/xor_gate_unit.sv
// Bitwise XOR primitive: combinational y, registered valid-qualified y_q/parity_q.
// Saturating acceptance statistics are built only when XOR_GATE_STATS_EN is defined.
module xor_gate_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             parity_q,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0] xor_d;
  logic             parity_d;

  assign xor_d    = a ^ b;
  assign parity_d = ^xor_d;
  assign y        = xor_d;

  // Result registers hold their value while idle; only out_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      parity_q  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q      <= xor_d;
        parity_q <= parity_d;
      end
    end
  end

`ifdef XOR_GATE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] ones_r;
  logic [CNT_W-1:0] xfer_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_r <= '0;
      xfer_r <= '0;
    end else if (in_valid) begin
      if (xfer_r != CNT_MAX)
        xfer_r <= xfer_r + CNT_W'(1);
      if (parity_d && (ones_r != CNT_MAX))
        ones_r <= ones_r + CNT_W'(1);
    end
  end

  assign ones_cnt = ones_r;
  assign xfer_cnt = xfer_r;
`else
  assign ones_cnt = '0;
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_xor_gate_unit.sv
// Self-checking bench for xor_gate_unit: directed plan cases plus random traffic
// against a count-based reference model.
module tb_xor_gate_unit;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  a, b;
  logic          in_valid;
  logic [W-1:0]  y, y_q;
  logic          out_valid, parity_q;
  logic [CW-1:0] ones_cnt, xfer_cnt;

  logic          a1, b1, in_valid1;
  logic          y1, y_q1, out_valid1, parity_q1;
  logic [CW-1:0] ones_cnt1, xfer_cnt1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // reference model state
  logic [W-1:0] exp_yq;
  logic         exp_par;
  logic         exp_ov;
  int           acc_n;
  int           odd_n;

  xor_gate_unit #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .y(y), .y_q(y_q), .out_valid(out_valid), .parity_q(parity_q),
    .ones_cnt(ones_cnt), .xfer_cnt(xfer_cnt)
  );

  xor_gate_unit #(.WIDTH(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid1),
    .y(y1), .y_q(y_q1), .out_valid(out_valid1), .parity_q(parity_q1),
    .ones_cnt(ones_cnt1), .xfer_cnt(xfer_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, ".y_q"}, 64'(y_q), 64'(exp_yq));
    chk({tag, ".parity_q"}, 64'(parity_q), 64'(exp_par));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
`ifdef XOR_GATE_STATS_EN
    chk({tag, ".xfer_cnt"}, 64'(xfer_cnt), 64'(sat(acc_n)));
    chk({tag, ".ones_cnt"}, 64'(ones_cnt), 64'(sat(odd_n)));
`else
    chk({tag, ".xfer_cnt"}, 64'(xfer_cnt), 64'd0);
    chk({tag, ".ones_cnt"}, 64'(ones_cnt), 64'd0);
`endif
  endtask

  task automatic model_reset();
    exp_yq  = '0;
    exp_par = 1'b0;
    exp_ov  = 1'b0;
    acc_n   = 0;
    odd_n   = 0;
  endtask

  // Drive one cycle of stimulus, check y before the edge and registers after it.
  task automatic cycle(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tv);
    logic [W-1:0] r;
    a = ta; b = tb; in_valid = tv;
    r = ta ^ tb;
    #1 chk({tag, ".y"}, 64'(y), 64'(r));
    @(posedge clk);
    exp_ov = tv;
    if (tv) begin
      exp_yq  = r;
      exp_par = ($countones(r) % 2) == 1;
      acc_n++;
      if (exp_par) odd_n++;
    end
    #1 chk_regs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 chk_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         want;
    rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b0;
    model_reset();

    #2 chk_regs("reset");
    a = 8'hF0; b = 8'h3C;
    #1 chk("reset.y_tracks", 64'(y), 64'hCC);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // single-bit truth table
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      #10 chk("w1.y", 64'(y1), 64'(ab[1] != ab[0]));
    end

    cycle("f0_3c", 8'hF0, 8'h3C, 1'b1);
    chk("f0_3c.value", 64'(y_q), 64'hCC);
    cycle("f0_3c_idle", 8'h00, 8'h00, 1'b0);
    chk("f0_3c.hold", 64'(y_q), 64'hCC);

    cycle("b2b0", 8'hA5, 8'hA4, 1'b1);
    cycle("b2b1", 8'h5A, 8'h59, 1'b1);
    cycle("b2b2", 8'hFF, 8'hF8, 1'b1);
    cycle("b2b_end", 8'h00, 8'h00, 1'b0);

    // async reset while out_valid is high, between clock edges
    cycle("pre_rst", 8'h12, 8'h34, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    a = 8'h0F; b = 8'hFF;
    #1 chk_regs("async_rst");
    chk("async_rst.y", 64'(y), 64'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycle("post_rst", 8'h81, 8'h00, 1'b1);

    // stats: 20 accepted, 12 with odd parity
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      want = (i % 5) < 3;
      if ((($countones(ra ^ rb) % 2) == 1) != want) rb[0] = ~rb[0];
      cycle("stats", ra, rb, 1'b1);
    end
`ifdef XOR_GATE_STATS_EN
    chk("stats.xfer_sat", 64'(xfer_cnt), 64'd15);
    chk("stats.ones", 64'(ones_cnt), 64'd12);
`else
    chk("stats.xfer_off", 64'(xfer_cnt), 64'd0);
    chk("stats.ones_off", 64'(ones_cnt), 64'd0);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 200; i++)
      cycle("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 2) != 0));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/xor_gate_unit.md
Name: xor_gate_unit

Overview:
- Bitwise XOR datapath element with a combinational output and a registered, valid-qualified output path.
- Used as the basic XOR primitive in small logic/ALU datapaths. The combinational path serves glue logic; the registered path serves pipelined consumers.
- Adds a registered reduction-parity output and an optional statistics block.

Parameters:
- WIDTH, 1, operand/result width in bits (legal range 1..64).
- CNT_W, 16, width of the statistics counters (legal range 4..32).

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for the registered path.
- y  output  WIDTH  combinational a ^ b.
- y_q  output  WIDTH  registered a ^ b.
- out_valid  output  1  y_q/parity_q hold a fresh result.
- parity_q  output  1  registered XOR-reduction of (a ^ b).
- ones_cnt  output  CNT_W  stats: saturating count of accepted results with parity 1 (only with XOR_GATE_STATS_EN).
- xfer_cnt  output  CNT_W  stats: saturating count of accepted results (only with XOR_GATE_STATS_EN).

Behaviour:
- Combinational path:
  - y = a ^ b, bitwise, zero latency.
  - No dependence on clk, rst_n or in_valid; y is valid during reset.
  - Truth table per bit: 0^0=0, 0^1=1, 1^0=1, 1^1=0.
  - X/Z on an input bit propagates to the corresponding y bit (4-state simulation).
- Registered path, latency 1 cycle:
  - On a rising clk with in_valid=1: y_q <= a ^ b, parity_q <= ^(a ^ b), out_valid <= 1.
  - On a rising clk with in_valid=0: out_valid <= 0. y_q and parity_q hold their previous values.
  - out_valid is a one-cycle pulse per accepted input. Back-to-back in_valid gives continuous out_valid.
  - No backpressure: every valid input is accepted.
- Reset (asynchronous assert, synchronous-to-clk deassert handled externally):
  - rst_n=0 forces y_q=0, parity_q=0, out_valid=0, ones_cnt=0, xfer_cnt=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-stream discards the in-flight result.
  - The first edge after rst_n rises samples normally.
- Width rules:
  - parity_q for WIDTH=1 equals y_q.
  - No sign semantics; operands are unsigned bit vectors.

Optional Feature:
- Macro XOR_GATE_STATS_EN.
- Defined:
  - xfer_cnt increments on each accepted input (in_valid=1 at a clk edge).
  - ones_cnt increments on each accepted input whose ^(a^b)=1.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - Both counters reset to 0.
- Undefined: counters are not instantiated and ones_cnt/xfer_cnt are tied to constant 0. The ports remain present.

Test Plan:
- WIDTH=1: drive a,b = 00, 01, 10, 11, holding each 10 ns -> y = 0, 1, 1, 0. The 11 case must give 0.
- WIDTH=8: a=8'hF0, b=8'h3C, in_valid=1 for one cycle -> next cycle y_q=8'hCC, parity_q=0, out_valid=1; following cycle out_valid=0 with y_q held at 8'hCC.
- Back-to-back: in_valid=1 for 3 cycles with a^b = 8'h01, 8'h03, 8'h07 -> y_q sequence 01, 03, 07; parity_q sequence 1, 0, 1; out_valid high for 3 cycles.
- Async reset: assert rst_n=0 between clock edges while out_valid=1 -> y_q, parity_q, out_valid go to 0 with no clk edge. y keeps tracking a^b during reset.
- Stats (XOR_GATE_STATS_EN, CNT_W=4): 20 accepted inputs, 12 of them with parity 1 -> xfer_cnt=15 (saturated), ones_cnt=12.
- Without XOR_GATE_STATS_EN: the same stimulus gives ones_cnt=0 and xfer_cnt=0.
